// File: rtl/wb_trace_serializer_if.sv
// -----------------------------------------------------------------------------
// wb_trace_serializer_if
// Groups the dual writeback commit channels and the serialized debug trace port
// of wb_trace_serializer.
//   master : drives the wb0_*/wb1_* commit channels (pipeline / testbench) and
//            observes wb_stall, debug_wb_*, commit_cnt and overflow_err.
//   slave  : the serializer itself.
// Signals:
//   wb0_valid/wen/rd/wdata/pc  channel 0 commit (older instruction)
//   wb1_valid/wen/rd/wdata/pc  channel 1 commit (younger instruction)
//   wb_stall                   fewer than two FIFO slots free
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata  one emitted entry per cycle, 0 when idle
//   commit_cnt                 accepted committed instructions (wraps)
//   overflow_err               sticky: a valid arrived while wb_stall was high
// -----------------------------------------------------------------------------
interface wb_trace_serializer_if;
   logic        wb0_valid;
   logic        wb0_wen;
   logic [4:0]  wb0_rd;
   logic [31:0] wb0_wdata;
   logic [31:0] wb0_pc;
   logic        wb1_valid;
   logic        wb1_wen;
   logic [4:0]  wb1_rd;
   logic [31:0] wb1_wdata;
   logic [31:0] wb1_pc;
   logic        wb_stall;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic [31:0] commit_cnt;
   logic        overflow_err;

   modport master (
      output wb0_valid, wb0_wen, wb0_rd, wb0_wdata, wb0_pc,
      output wb1_valid, wb1_wen, wb1_rd, wb1_wdata, wb1_pc,
      input  wb_stall, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
      input  debug_wb_rf_wdata, commit_cnt, overflow_err
   );

   modport slave (
      input  wb0_valid, wb0_wen, wb0_rd, wb0_wdata, wb0_pc,
      input  wb1_valid, wb1_wen, wb1_rd, wb1_wdata, wb1_pc,
      output wb_stall, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
      output debug_wb_rf_wdata, commit_cnt, overflow_err
   );
endinterface

// File: rtl/wb_trace_serializer.sv
// -----------------------------------------------------------------------------
// wb_trace_serializer
// Serializes the two writeback channels of the dual-issue datapath onto the
// single debug_wb_* trace port. Committed writebacks are held in an in-order
// FIFO and emitted one per cycle, channel 0 before channel 1.
// Ports:
//   clock  core clock
//   reset  synchronous, active-high; flushes the FIFO and clears all outputs
//   wb     wb_trace_serializer_if.slave (commit channels in, trace port out)
// Parameters:
//   DEPTH  FIFO entries, power of two, >= 4
//   AW     log2(DEPTH)
// Configuration macro:
//   WB_TRACE_FILTER_EN  when defined, valids with wen=0 or rd=0 are counted in
//                       commit_cnt but never enqueued.
// -----------------------------------------------------------------------------
module wb_trace_serializer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   wb_trace_serializer_if.slave   wb
);

   localparam int             EW        = 70;   // {wen, rd[4:0], wdata[31:0], pc[31:0]}
   localparam logic [AW:0]    STALL_LVL = (AW+1)'(DEPTH - 1);

   logic [EW-1:0] mem_q [DEPTH];

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   commit_cnt_q, commit_cnt_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   out_pc_q, out_pc_d;
   logic [3:0]    out_wen_q, out_wen_d;
   logic [4:0]    out_wnum_q, out_wnum_d;
   logic [31:0]   out_wdata_q, out_wdata_d;

   logic          stall_s;
   logic          acc0_s, acc1_s;
   logic          keep0_s, keep1_s;
   logic          pop_s;
   logic [1:0]    n_acc_s, n_enq_s;
   logic [AW-1:0] wr1_idx_s;
   logic [EW-1:0] ent0_s, ent1_s, head_s;

   // Acceptance, filtering and slot selection for this cycle's commits.
   always_comb begin
      // Registered count only, so two slots are guaranteed free while low.
      stall_s = (count_q >= STALL_LVL);
      acc0_s  = wb.wb0_valid & ~stall_s;
      acc1_s  = wb.wb1_valid & ~stall_s;
`ifdef WB_TRACE_FILTER_EN
      keep0_s = acc0_s & wb.wb0_wen & (wb.wb0_rd != 5'd0);
      keep1_s = acc1_s & wb.wb1_wen & (wb.wb1_rd != 5'd0);
`else
      keep0_s = acc0_s;
      keep1_s = acc1_s;
`endif
      n_acc_s   = {1'b0, acc0_s} + {1'b0, acc1_s};
      n_enq_s   = {1'b0, keep0_s} + {1'b0, keep1_s};
      // ch1 lands right after ch0 only when ch0 actually occupies a slot.
      wr1_idx_s = wr_ptr_q + AW'(keep0_s);
      pop_s     = (count_q != {(AW+1){1'b0}});
      ent0_s    = {wb.wb0_wen, wb.wb0_rd, wb.wb0_wdata, wb.wb0_pc};
      ent1_s    = {wb.wb1_wen, wb.wb1_rd, wb.wb1_wdata, wb.wb1_pc};
      head_s    = mem_q[rd_ptr_q];
   end

   // Next-state for pointers, occupancy, counters and the trace output register.
   always_comb begin
      wr_ptr_d     = wr_ptr_q + AW'(n_enq_s);
      rd_ptr_d     = rd_ptr_q + AW'(pop_s);
      count_d      = count_q + (AW+1)'(n_enq_s) - (AW+1)'(pop_s);
      commit_cnt_d = commit_cnt_q + 32'(n_acc_s);
      ovf_d        = ovf_q | ((wb.wb0_valid | wb.wb1_valid) & stall_s);
      if (pop_s) begin
         // An entry that writes x0 or does not write is reported as no write.
         out_wen_d   = {4{head_s[69] & (head_s[68:64] != 5'd0)}};
         out_wnum_d  = head_s[68:64];
         out_wdata_d = head_s[63:32];
         out_pc_d    = head_s[31:0];
      end else begin
         out_wen_d   = 4'h0;
         out_wnum_d  = 5'd0;
         out_wdata_d = 32'd0;
         out_pc_d    = 32'd0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q     <= {AW{1'b0}};
         wr_ptr_q     <= {AW{1'b0}};
         count_q      <= {(AW+1){1'b0}};
         commit_cnt_q <= 32'd0;
         ovf_q        <= 1'b0;
         out_pc_q     <= 32'd0;
         out_wen_q    <= 4'h0;
         out_wnum_q   <= 5'd0;
         out_wdata_q  <= 32'd0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         commit_cnt_q <= commit_cnt_d;
         ovf_q        <= ovf_d;
         out_pc_q     <= out_pc_d;
         out_wen_q    <= out_wen_d;
         out_wnum_q   <= out_wnum_d;
         out_wdata_q  <= out_wdata_d;
      end
   end

   // FIFO storage writes; contents need no reset since count gates reads.
   always_ff @(posedge clock) begin
      if (!reset && keep0_s) begin
         mem_q[wr_ptr_q] <= ent0_s;
      end
      if (!reset && keep1_s) begin
         mem_q[wr1_idx_s] <= ent1_s;
      end
   end

   assign wb.wb_stall          = stall_s;
   assign wb.debug_wb_pc       = out_pc_q;
   assign wb.debug_wb_rf_wen   = out_wen_q;
   assign wb.debug_wb_rf_wnum  = out_wnum_q;
   assign wb.debug_wb_rf_wdata = out_wdata_q;
   assign wb.commit_cnt        = commit_cnt_q;
   assign wb.overflow_err      = ovf_q;

endmodule

// File: tb/tb_wb_trace_serializer.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_serializer
// Directed, table-driven bench for wb_trace_serializer (DEPTH=8). Each table
// row drives one cycle of commits and holds the outputs expected just after
// that cycle's clock edge. Hand-written sequences cover reset, fill-to-stall,
// overflow and drain. Expectations follow WB_TRACE_FILTER_EN when defined.
// -----------------------------------------------------------------------------
module tb_wb_trace_serializer;

   typedef struct {
      logic        v0, w0; logic [4:0] r0; logic [31:0] d0, p0;
      logic        v1, w1; logic [4:0] r1; logic [31:0] d1, p1;
      logic [31:0] epc; logic [3:0] ewen; logic [4:0] ewnum;
      logic [31:0] edata; logic [31:0] ecnt;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_pass = 0;
   int   n_tot  = 0;

   wb_trace_serializer_if bus();

   wb_trace_serializer #(.DEPTH(8), .AW(3)) dut (
      .clock (clock),
      .reset (reset),
      .wb    (bus)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(
      input logic v0, input logic w0, input logic [4:0] r0, input logic [31:0] d0, input logic [31:0] p0,
      input logic v1, input logic w1, input logic [4:0] r1, input logic [31:0] d1, input logic [31:0] p1,
      input logic [31:0] epc, input logic [3:0] ewen, input logic [4:0] ewnum,
      input logic [31:0] edata, input logic [31:0] ecnt);
      vec_t v;
      v.v0 = v0; v.w0 = w0; v.r0 = r0; v.d0 = d0; v.p0 = p0;
      v.v1 = v1; v.w1 = w1; v.r1 = r1; v.d1 = d1; v.p1 = p1;
      v.epc = epc; v.ewen = ewen; v.ewnum = ewnum; v.edata = edata; v.ecnt = ecnt;
      return v;
   endfunction

   function automatic logic [127:0] obs();
      return {21'd0, bus.wb_stall, bus.debug_wb_pc, bus.debug_wb_rf_wen, bus.debug_wb_rf_wnum,
              bus.debug_wb_rf_wdata, bus.commit_cnt, bus.overflow_err};
   endfunction

   function automatic logic [127:0] expv(input logic stall, input logic [31:0] pc, input logic [3:0] wen,
                                         input logic [4:0] wnum, input logic [31:0] wdata,
                                         input logic [31:0] cnt, input logic ovf);
      return {21'd0, stall, pc, wen, wnum, wdata, cnt, ovf};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h (stall,pc,wen,wnum,wdata,cnt,ovf)", nm, act, exp);
   endtask

   task automatic idle_in();
      bus.wb0_valid = 1'b0; bus.wb0_wen = 1'b0; bus.wb0_rd = 5'd0; bus.wb0_wdata = 32'd0; bus.wb0_pc = 32'd0;
      bus.wb1_valid = 1'b0; bus.wb1_wen = 1'b0; bus.wb1_rd = 5'd0; bus.wb1_wdata = 32'd0; bus.wb1_pc = 32'd0;
   endtask

   task automatic drive(input vec_t v);
      bus.wb0_valid = v.v0; bus.wb0_wen = v.w0; bus.wb0_rd = v.r0; bus.wb0_wdata = v.d0; bus.wb0_pc = v.p0;
      bus.wb1_valid = v.v1; bus.wb1_wen = v.w1; bus.wb1_rd = v.r1; bus.wb1_wdata = v.d1; bus.wb1_pc = v.p1;
   endtask

   // Hold reset for n cycles with random commit traffic; outputs must stay 0.
   task automatic do_reset(input int n, input string nm);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         bus.wb0_valid = 1'($urandom); bus.wb0_wen = 1'($urandom); bus.wb0_rd = 5'($urandom);
         bus.wb0_wdata = $urandom; bus.wb0_pc = $urandom;
         bus.wb1_valid = 1'($urandom); bus.wb1_wen = 1'($urandom); bus.wb1_rd = 5'($urandom);
         bus.wb1_wdata = $urandom; bus.wb1_pc = $urandom;
         @(posedge clock); #1;
         check($sformatf("%s_c%0d", nm, i), obs(), 128'd0);
      end
      @(negedge clock);
      reset = 1'b0;
      idle_in();
   endtask

   function automatic logic [69:0] t4_entry(input int n);
      return {1'b1, 5'(n % 31 + 1), 32'hA000_0000 + 32'(n), 32'h8000_1000 + 32'(4 * n)};
   endfunction

   vec_t        tbl [14];
   logic [69:0] q [$];
   logic [69:0] em;
   logic        em_v;
   logic        mstall;
   logic        movf;
   logic        ovf_done;
   logic        saw_stall;
   int          mcnt;
   int          sent;
   logic [31:0] mcommit;

   initial begin
      idle_in();

      // Row: inputs for one cycle, outputs expected right after that edge.
      tbl[0]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           0,4'h0,0,0,0);
      tbl[1]  = mk(1,1,5,32'h1234,32'hbfc00000,        0,0,0,0,0,                           0,4'h0,0,0,1);
      tbl[2]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           32'hbfc00000,4'hf,5,32'h1234,1);
      tbl[3]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           0,4'h0,0,0,1);
      tbl[4]  = mk(1,1,2,32'h22,32'hbfc00010,          1,1,3,32'h33,32'hbfc00014,           0,4'h0,0,0,3);
      tbl[5]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           32'hbfc00010,4'hf,2,32'h22,3);
      tbl[6]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           32'hbfc00014,4'hf,3,32'h33,3);
      tbl[7]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           0,4'h0,0,0,3);
      tbl[8]  = mk(1,1,0,32'haa,32'hbfc00020,          1,1,9,32'h99,32'hbfc00024,           0,4'h0,0,0,5);
`ifdef WB_TRACE_FILTER_EN
      tbl[9]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           32'hbfc00024,4'hf,9,32'h99,5);
      tbl[10] = mk(0,0,0,0,0,                           0,0,0,0,0,                           0,4'h0,0,0,5);
`else
      tbl[9]  = mk(0,0,0,0,0,                           0,0,0,0,0,                           32'hbfc00020,4'h0,0,32'haa,5);
      tbl[10] = mk(0,0,0,0,0,                           0,0,0,0,0,                           32'hbfc00024,4'hf,9,32'h99,5);
`endif
      tbl[11] = mk(0,0,0,0,0,                           0,0,0,0,0,                           0,4'h0,0,0,5);
      tbl[12] = mk(0,0,0,0,0,                           1,0,4,32'h44,32'hbfc00030,           0,4'h0,0,0,6);
`ifdef WB_TRACE_FILTER_EN
      tbl[13] = mk(0,0,0,0,0,                           0,0,0,0,0,                           0,4'h0,0,0,6);
`else
      tbl[13] = mk(0,0,0,0,0,                           0,0,0,0,0,                           32'hbfc00030,4'h0,4,32'h44,6);
`endif

      // Reset held 3 cycles under random traffic.
      do_reset(3, "reset");

      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         drive(tbl[i]);
         @(posedge clock); #1;
         check($sformatf("vec%0d", i), obs(),
               expv(1'b0, tbl[i].epc, tbl[i].ewen, tbl[i].ewnum, tbl[i].edata, tbl[i].ecnt, 1'b0));
      end

      // Fill with dual commits until stall, one overflow attempt, then drain.
      do_reset(1, "reset_t4");
      mcnt = 0; sent = 0; mcommit = 32'd0; movf = 1'b0; ovf_done = 1'b0; saw_stall = 1'b0;
      q.delete();
      for (int s = 0; s < 24; s++) begin
         @(negedge clock);
         idle_in();
         mstall = (mcnt >= 7);
         if (mstall) saw_stall = 1'b1;
         em_v = (mcnt != 0);
         em   = 70'd0;
         if (em_v) begin
            em = q.pop_front();
            mcnt--;
         end
         if (!mstall && sent < 12) begin
            {bus.wb0_wen, bus.wb0_rd, bus.wb0_wdata, bus.wb0_pc} = t4_entry(sent);
            {bus.wb1_wen, bus.wb1_rd, bus.wb1_wdata, bus.wb1_pc} = t4_entry(sent + 1);
            bus.wb0_valid = 1'b1; bus.wb1_valid = 1'b1;
            q.push_back(t4_entry(sent));
            q.push_back(t4_entry(sent + 1));
            sent += 2; mcnt += 2; mcommit += 32'd2;
         end else if (mstall && !ovf_done) begin
            {bus.wb0_wen, bus.wb0_rd, bus.wb0_wdata, bus.wb0_pc} = t4_entry(99);
            bus.wb0_valid = 1'b1;
            ovf_done = 1'b1;
            movf = 1'b1;
         end
         @(posedge clock); #1;
         if (em_v)
            check($sformatf("t4_s%0d", s), obs(),
                  expv(mcnt >= 7, em[31:0], 4'hf, em[68:64], em[63:32], mcommit, movf));
         else
            check($sformatf("t4_s%0d", s), obs(),
                  expv(mcnt >= 7, 32'd0, 4'h0, 5'd0, 32'd0, mcommit, movf));
      end
      n_tot++;
      if (saw_stall && ovf_done && sent == 12 && q.size() == 0) n_pass++;
      else $display("FAIL t4_sequence saw_stall=%0b ovf_done=%0b sent=%0d left=%0d required 1/1/12/0",
                    saw_stall, ovf_done, sent, q.size());

      // Reset clears the sticky overflow flag.
      do_reset(1, "reset_ovf");
      @(negedge clock);
      idle_in();
      @(posedge clock); #1;
      check("post_reset_idle", obs(), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
